// File: rtl/regfile_pkg.sv
// Shared defaults and index helpers for the multi-port register file with busy scoreboard.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;

   // Index width for a register count; never collapses to zero bits.
   function automatic int addr_width(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   // LSB of read port k inside a flattened bus of w-bit fields (addresses or data).
   function automatic int rd_slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding long-latency results, with running count and WAW flag.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = addr_width(NUM_REGS),
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                iss_en,
   input  logic [ADDR_W-1:0]   iss_addr,
   input  logic                wb_en,
   input  logic [ADDR_W-1:0]   wb_addr,
   output logic [NUM_REGS-1:0] busy,
   output logic [ADDR_W:0]     busy_count,
   output logic                all_idle,
   output logic                iss_err
);

   logic set_v;
   logic same_reg;
   logic cnt_inc;
   logic cnt_dec;

   assign set_v    = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
   assign same_reg = wb_en && (wb_addr == iss_addr);

   // A set on a register being cleared in the same cycle keeps it busy, so the count holds.
   assign cnt_inc = set_v && !busy[iss_addr];
   assign cnt_dec = wb_en && busy[wb_addr] && !(set_v && (iss_addr == wb_addr));

   assign all_idle = (busy_count == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy       <= '0;
         busy_count <= '0;
         iss_err    <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (set_v && (iss_addr == ADDR_W'(r)))
               busy[r] <= 1'b1;
            else if (wb_en && (wb_addr == ADDR_W'(r)))
               busy[r] <= 1'b0;
         end
         if (cnt_inc && !cnt_dec)
            busy_count <= busy_count + {{ADDR_W{1'b0}}, 1'b1};
         else if (cnt_dec && !cnt_inc)
            busy_count <= busy_count - {{ADDR_W{1'b0}}, 1'b1};
         iss_err <= set_v && busy[iss_addr] && !same_reg;
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file with same-cycle bypass and NPU busy scoreboard.
// Optional per-register even parity with rd_perr output when REGFILE_PARITY_EN is defined.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = addr_width(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
`ifdef REGFILE_PARITY_EN
   output logic [NUM_RD-1:0]        rd_perr,
`endif
   input  logic                     wa_en,
   input  logic [ADDR_W-1:0]        wa_addr,
   input  logic [DATA_W-1:0]        wa_data,
   input  logic                     wb_en,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic [ADDR_W:0]          busy_count,
   output logic                     all_idle,
   output logic                     wr_conflict,
   output logic                     iss_err
);

   logic [DATA_W-1:0]   mem [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic                wa_ok;
   logic                wb_ok;
`ifdef REGFILE_PARITY_EN
   logic [NUM_REGS-1:0] par_q;
`endif

   // Port A wins a same-address collision; port B only clears busy in that case.
   assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
   assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0))
                  && !(wa_ok && (wa_addr == wb_addr));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++)
            mem[r] <= '0;
`ifdef REGFILE_PARITY_EN
         par_q <= '0;
`endif
         wr_conflict <= 1'b0;
      end else begin
         if (wb_ok) begin
            mem[wb_addr] <= wb_data;
`ifdef REGFILE_PARITY_EN
            par_q[wb_addr] <= ^wb_data;
`endif
         end
         if (wa_ok) begin
            mem[wa_addr] <= wa_data;
`ifdef REGFILE_PARITY_EN
            par_q[wa_addr] <= ^wa_data;
`endif
         end
         wr_conflict <= wa_ok && wb_en && (wa_addr == wb_addr);
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zero_hit;
      logic              a_hit;
      logic              b_hit;

      assign a        = rd_addr[rd_slice_lo(k, ADDR_W) +: ADDR_W];
      assign zero_hit = (ZERO_REG != 0) && (a == '0);
      assign a_hit    = wa_en && (wa_addr == a);
      assign b_hit    = wb_en && (wb_addr == a);

      assign rd_data[rd_slice_lo(k, DATA_W) +: DATA_W] =
         zero_hit ? '0      :
         a_hit    ? wa_data :
         b_hit    ? wb_data :
                    mem[a];

      // A matching writeback retires the hazard in the cycle it arrives.
      assign rd_busy[k] = busy[a] && !b_hit;

`ifdef REGFILE_PARITY_EN
      assign rd_perr[k] = (zero_hit || a_hit || b_hit) ? 1'b0 : ((^mem[a]) ^ par_q[a]);
`endif
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .iss_en     (iss_en),
      .iss_addr   (iss_addr),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .busy       (busy),
      .busy_count (busy_count),
      .all_idle   (all_idle),
      .iss_err    (iss_err)
   );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_mp_sb;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int RD = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [RD*AW-1:0] rd_addr;
   logic [RD*DW-1:0] rd_data;
   logic [RD-1:0]    rd_busy;
`ifdef REGFILE_PARITY_EN
   logic [RD-1:0]    rd_perr;
`endif
   logic             wa_en, wb_en, iss_en;
   logic [AW-1:0]    wa_addr, wb_addr, iss_addr;
   logic [DW-1:0]    wa_data, wb_data;
   logic [AW:0]      busy_count;
   logic             all_idle, wr_conflict, iss_err;

   regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD), .ZERO_REG(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
`ifdef REGFILE_PARITY_EN
      .rd_perr     (rd_perr),
`endif
      .wa_en       (wa_en),
      .wa_addr     (wa_addr),
      .wa_data     (wa_data),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .iss_en      (iss_en),
      .iss_addr    (iss_addr),
      .busy_count  (busy_count),
      .all_idle    (all_idle),
      .wr_conflict (wr_conflict),
      .iss_err     (iss_err)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 0;

   // Behavioural model: architectural contents, busy set, and last-cycle event flags.
   logic [DW-1:0] mem_m [NR];
   bit            busy_m [NR];
   bit            conflict_m;
   bit            err_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
   endtask

   function automatic int pop_busy();
      int c = 0;
      for (int r = 0; r < NR; r++) c += busy_m[r] ? 1 : 0;
      return c;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (wa_en && wa_addr == a) return wa_data;
      if (wb_en && wb_addr == a) return wb_data;
      return mem_m[a];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NR; r++) begin
            mem_m[r]  = '0;
            busy_m[r] = 0;
         end
         conflict_m = 0;
         err_m      = 0;
      end else begin
         bit wa_w;
         wa_w       = wa_en && (wa_addr != 0);
         conflict_m = wa_w && wb_en && (wb_addr == wa_addr);
         err_m      = iss_en && (iss_addr != 0) && busy_m[iss_addr]
                      && !(wb_en && wb_addr == iss_addr);
         if (wb_en && wb_addr != 0 && !conflict_m) mem_m[wb_addr] = wb_data;
         if (wa_w) mem_m[wa_addr] = wa_data;
         if (wb_en) busy_m[wb_addr] = 0;
         if (iss_en && iss_addr != 0) busy_m[iss_addr] = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < RD; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            chk($sformatf("rd_data%0d", k), 64'(rd_data[k*DW +: DW]), 64'(exp_rd(a)));
            chk($sformatf("rd_busy%0d", k), 64'(rd_busy[k]),
                64'(busy_m[a] && !(wb_en && wb_addr == a)));
`ifdef REGFILE_PARITY_EN
            chk($sformatf("rd_perr%0d", k), 64'(rd_perr[k]), 64'(0));
`endif
         end
         chk("busy_count", 64'(busy_count), 64'(pop_busy()));
         chk("all_idle", 64'(all_idle), 64'(pop_busy() == 0));
         chk("wr_conflict", 64'(wr_conflict), 64'(conflict_m));
         chk("iss_err", 64'(iss_err), 64'(err_m));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wa_en = 0; wb_en = 0; iss_en = 0;
   endtask

   task automatic set_rd(input int k, input int a);
      rd_addr[k*AW +: AW] = AW'(a);
   endtask

   initial begin
      rst_n = 0; rd_addr = '0;
      wa_en = 0; wa_addr = '0; wa_data = '0;
      wb_en = 0; wb_addr = '0; wb_data = '0;
      iss_en = 0; iss_addr = '0;
      next_cycle();
      next_cycle();
      chk_en = 1;
      rst_n  = 1;
      set_rd(0, 5); set_rd(1, 5);
      @(negedge clk);
      chk("rst_rd0", 64'(rd_data[31:0]), 64'h0);
      chk("rst_rd1", 64'(rd_data[63:32]), 64'h0);
      chk("rst_busy", 64'(rd_busy), 64'h0);
      chk("rst_idle", 64'(all_idle), 64'h1);
      chk("rst_cnt", 64'(busy_count), 64'h0);

      // Port A bypass then stored value.
      next_cycle();
      wa_en = 1; wa_addr = 3; wa_data = 32'hDEADBEEF; set_rd(0, 3);
      @(negedge clk);
      chk("bypass_a", 64'(rd_data[31:0]), 64'hDEADBEEF);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk("stored_a", 64'(rd_data[31:0]), 64'hDEADBEEF);

      // A/B collision on r7.
      next_cycle();
      wa_en = 1; wa_addr = 7; wa_data = 32'h11111111;
      wb_en = 1; wb_addr = 7; wb_data = 32'h22222222; set_rd(0, 7);
      @(negedge clk);
      chk("coll_bypass", 64'(rd_data[31:0]), 64'h11111111);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk("coll_data", 64'(rd_data[31:0]), 64'h11111111);
      chk("coll_flag1", 64'(wr_conflict), 64'h1);
      next_cycle();
      @(negedge clk);
      chk("coll_flag0", 64'(wr_conflict), 64'h0);

      // Issue r9, wait, then writeback.
      next_cycle();
      iss_en = 1; iss_addr = 9; set_rd(0, 9);
      next_cycle();
      idle_inputs();
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("iss_busy", 64'(rd_busy[0]), 64'h1);
      chk("iss_cnt", 64'(busy_count), 64'h1);
      next_cycle();
      wb_en = 1; wb_addr = 9; wb_data = 32'hCAFE0000;
      @(negedge clk);
      chk("wb_bypass", 64'(rd_data[31:0]), 64'hCAFE0000);
      chk("wb_busy_byp", 64'(rd_busy[0]), 64'h0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk("wb_cnt0", 64'(busy_count), 64'h0);

      // WAW on r9, then set+clear on busy r4.
      next_cycle();
      iss_en = 1; iss_addr = 9;
      next_cycle();
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk("waw_err", 64'(iss_err), 64'h1);
      chk("waw_cnt", 64'(busy_count), 64'h1);
      next_cycle();
      iss_en = 1; iss_addr = 4;
      @(negedge clk);
      chk("waw_err_once", 64'(iss_err), 64'h0);
      next_cycle();
      wb_en = 1; wb_addr = 4; wb_data = 32'h4444;
      next_cycle();
      idle_inputs(); set_rd(0, 4);
      @(negedge clk);
      chk("setclr_busy", 64'(rd_busy[0]), 64'h1);
      chk("setclr_err", 64'(iss_err), 64'h0);
      chk("setclr_cnt", 64'(busy_count), 64'h2);
      next_cycle();
      wb_en = 1; wb_addr = 4;
      next_cycle();
      wb_addr = 9;
      next_cycle();
      idle_inputs();

      // Zero register ignores writes and issues.
      wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; set_rd(0, 0);
      @(negedge clk);
      chk("zero_byp", 64'(rd_data[31:0]), 64'h0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk("zero_rd", 64'(rd_data[31:0]), 64'h0);
      chk("zero_cnt", 64'(busy_count), 64'h0);
      chk("zero_err", 64'(iss_err), 64'h0);

      // Randomized traffic on a narrow address range to force collisions and hazards.
      for (int i = 0; i < 2000; i++) begin
         next_cycle();
         rst_n    = ($urandom_range(0, 299) != 0);
         wa_en    = ($urandom_range(0, 2) == 0);
         wa_addr  = AW'($urandom_range(0, 7));
         wa_data  = $urandom;
         wb_en    = ($urandom_range(0, 2) == 0);
         wb_addr  = AW'($urandom_range(0, 7));
         wb_data  = $urandom;
         iss_en   = ($urandom_range(0, 3) == 0);
         iss_addr = AW'($urandom_range(0, 7));
         set_rd(0, $urandom_range(0, 7));
         set_rd(1, $urandom_range(0, 7));
      end
      next_cycle();
      idle_inputs();
      rst_n = 1;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the softcore's 32x32 register file.
- Adds configurable width, depth and read-port count.
- Adds a second write port for long-latency NPU writeback, plus write-to-read bypass.
- Adds a per-register busy scoreboard so the issue stage can detect RAW/WAW hazards on outstanding NPU results.
- Sits between decode/issue and the ALU/NPU writeback paths.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of registers (power of two, >=2).
- ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override).
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing.
- rd_busy  out  NUM_RD  1 = addressed register has an outstanding NPU write.
- wa_en  in  1  write port A (ALU) enable.
- wa_addr  in  ADDR_W  port A address.
- wa_data  in  DATA_W  port A data.
- wb_en  in  1  write port B (NPU writeback) enable; clears busy.
- wb_addr  in  ADDR_W  port B address.
- wb_data  in  DATA_W  port B data.
- iss_en  in  1  long-latency op issued; marks iss_addr busy.
- iss_addr  in  ADDR_W  destination of the issued op.
- busy_count  out  ADDR_W+1  number of busy registers.
- all_idle  out  1  busy_count == 0.
- wr_conflict  out  1  registered pulse: A and B wrote the same register in the previous cycle.
- iss_err  out  1  registered pulse: issue targeted an already-busy register (WAW) in the previous cycle.

Behaviour:
- Reset (rst_n=0 at posedge): all registers 0, all busy bits 0, busy_count 0, wr_conflict 0, iss_err 0. Therefore all_idle=1, rd_busy=0 and rd_data=0 after reset.
- Writes commit at posedge. Port A and port B are independent when their addresses differ.
- A and B same address, both enabled: A's data commits. B still clears busy. wr_conflict=1 the next cycle.
- Reads are combinational, with a same-cycle bypass:
  - wa_en and addr match: return wa_data.
  - else wb_en and addr match: return wb_data.
  - else the stored value.
- With ZERO_REG=1:
  - Writes to reg 0 are discarded.
  - Reads of reg 0 return 0, with no bypass.
  - Issue to reg 0 is ignored (no busy set, no iss_err).
- Scoreboard, per register busy bit, next state:
  - iss_en & iss_addr==r: 1.
  - else wb_en & wb_addr==r: 0.
  - else hold.
  - Simultaneous set and clear on the same register: busy stays 1 (new op supersedes).
- iss_err: iss_en to a register already busy (and not being cleared by wb in the same cycle). Busy stays 1; the flag pulses 1 cycle later.
- wb_en to a non-busy register: data still commits; no error.
- rd_busy[k] reflects the pre-posedge busy state, with bypass: if wb_en matches rd_addr, rd_busy=0 in that cycle.
- busy_count updates each cycle by +1, -1 or 0 from the set/clear events. It never exceeds NUM_REGS - ZERO_REG and never underflows.
- Reset asserted mid-operation discards all pending busy state; late NPU writebacks after reset still write data.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - One even-parity bit is stored per register, computed on write.
  - Extra output rd_perr[NUM_RD], combinational, 1 when the stored word and its parity disagree. Bypassed reads always give 0.
  - Parity bits reset to 0.
- Undefined: no parity storage and no rd_perr port.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/NUM_REGS constants;
  - addr-width helper function;
  - read-port pack/unpack index helpers.
- One sub-module, regfile_scoreboard. It owns the busy bits, busy_count, all_idle and iss_err. The top level owns storage, bypass and wr_conflict.

Test Plan:
- Reset, then read r5 on both ports -> rd_data=0, rd_busy=0, all_idle=1, busy_count=0.
- wa_en, r3<=0xDEADBEEF, rd_addr0=3 same cycle -> rd_data0=0xDEADBEEF (bypass); next cycle with wa_en=0 -> still 0xDEADBEEF.
- wa and wb both to r7 (0x11111111 / 0x22222222) -> r7=0x11111111; wr_conflict=1 for exactly one cycle.
- iss r9, then 3 idle cycles -> rd_busy=1 on r9, busy_count=1; then wb r9=0xCAFE0000 -> same cycle rd_data=0xCAFE0000 and rd_busy=0; next cycle busy_count=0.
- iss r9 twice without wb -> iss_err pulses once, busy_count=1. Same-cycle iss r4 + wb r4 on busy r4 -> r4 stays busy, no iss_err.
- ZERO_REG=1: write 0xFFFFFFFF to r0 and issue r0 -> reads 0, busy_count unchanged. With REGFILE_PARITY_EN, force a flipped bit in r2 -> rd_perr=1.
